// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared widths, control-bundle layout and payload offsets for MIPS32 pipeline stages
package mips_pipe_pkg;
    localparam int CTRL_W_DEF = 9;
    localparam int DATA_W_DEF = 160;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMTOREG = 7;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_ALUSRC   = 0;
    localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;
    localparam int PL_PC4   = 128;
    localparam int PL_RD1   = 96;
    localparam int PL_RD2   = 64;
    localparam int PL_IMM   = 32;
    localparam int PL_INSTR = 0;
    typedef enum logic [1:0] {SB_EMPTY, SB_FULL, SB_SKID} sb_state_t;
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: one-entry skid buffer with registered upstream ready and flush
// Ports: Clk, Reset (sync, active-high); Valid_Up/Ready_Up/Data_Up upstream side;
//        Valid_Dn/Ready_Dn/Data_Dn downstream side; Flush empties the buffer.
module skid_buffer
    import mips_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Flush,
    input  logic         Valid_Up,
    output logic         Ready_Up,
    input  logic [W-1:0] Data_Up,
    output logic         Valid_Dn,
    input  logic         Ready_Dn,
    output logic [W-1:0] Data_Dn
);
    sb_state_t st, nxt;
    logic [W-1:0] m, s;
    logic rdy, in_x, out_x, ld_m_up, ld_m_s, ld_s;
    assign in_x     = Valid_Up & rdy;
    assign out_x    = (st != SB_EMPTY) & Ready_Dn;
    assign Ready_Up = rdy;
    assign Valid_Dn = st != SB_EMPTY;
    assign Data_Dn  = m;
    always_comb begin
        nxt     = st;
        ld_m_up = 1'b0;
        ld_m_s  = 1'b0;
        ld_s    = 1'b0;
        if (Flush) nxt = SB_EMPTY;
        else case (st)
            SB_EMPTY: begin
                nxt     = in_x ? SB_FULL : SB_EMPTY;
                ld_m_up = in_x;
            end
            SB_FULL: begin
                nxt     = out_x ? (in_x ? SB_FULL : SB_EMPTY) : (in_x ? SB_SKID : SB_FULL);
                ld_m_up = out_x & in_x;
                ld_s    = ~out_x & in_x;
            end
            SB_SKID: begin
                nxt    = out_x ? SB_FULL : SB_SKID;
                ld_m_s = out_x;
            end
            default: nxt = SB_EMPTY;
        endcase
    end
    // Ready is registered from the next state so no combinational path reaches upstream.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            st  <= SB_EMPTY;
            rdy <= 1'b0;
            m   <= '0;
            s   <= '0;
        end else begin
            st  <= nxt;
            rdy <= nxt != SB_SKID;
            if (ld_m_up) m <= Data_Up;
            else if (ld_m_s) m <= s;
            if (ld_s) s <= Data_Up;
        end
    end
endmodule

// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: ID/EX pipeline register with valid/ready, skid buffer, flush bubble and stall counter
// Ports: Clk, Reset (sync, active-high); Valid_ID/Ready_ID/Ctrl_ID/Data_ID from decode;
//        Valid_EX/Ready_EX/Ctrl_EX/Data_EX to execute; Flush kills held and incoming beats;
//        Count_Clear zeroes Stall_Count, the saturating count of back-pressured cycles.
module id_ex_skid_stage
    import mips_pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Valid_ID,
    output logic              Ready_ID,
    input  logic [CTRL_W-1:0] Ctrl_ID,
    input  logic [DATA_W-1:0] Data_ID,
    input  logic              Flush,
    output logic              Valid_EX,
    input  logic              Ready_EX,
    output logic [CTRL_W-1:0] Ctrl_EX,
    output logic [DATA_W-1:0] Data_EX,
    input  logic              Count_Clear,
    output logic [CNT_W-1:0]  Stall_Count
);
    logic [CTRL_W+DATA_W-1:0] m_out;
    skid_buffer #(.W(CTRL_W + DATA_W)) u_skid (
        .Clk      (Clk),
        .Reset    (Reset),
        .Flush    (Flush),
        .Valid_Up (Valid_ID),
        .Ready_Up (Ready_ID),
        .Data_Up  ({Ctrl_ID, Data_ID}),
        .Valid_Dn (Valid_EX),
        .Ready_Dn (Ready_EX),
        .Data_Dn  (m_out)
    );
    // An invalid slot must decode as a NOP downstream, so control is masked; data is left as-is.
    assign Ctrl_EX = Valid_EX ? m_out[DATA_W +: CTRL_W] : CTRL_W'(CTRL_BUBBLE);
    assign Data_EX = m_out[DATA_W-1:0];
    always_ff @(posedge Clk) begin
        if (Reset || Count_Clear) Stall_Count <= '0;
        else if (Valid_EX && !Ready_EX && !(&Stall_Count)) Stall_Count <= Stall_Count + CNT_W'(1);
    end
endmodule

// File: tb/tb_id_ex_skid_stage.sv
// tb_id_ex_skid_stage: directed self-checking bench for id_ex_skid_stage
module tb_id_ex_skid_stage;
    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Valid_ID = 1'b0;
    logic [8:0]   Ctrl_ID = '0;
    logic [159:0] Data_ID = '0;
    logic         Flush = 1'b0;
    logic         Ready_EX = 1'b0;
    logic         Count_Clear = 1'b0;
    logic         Ready_ID, Valid_EX, Ready_ID2, Valid_EX2;
    logic [8:0]   Ctrl_EX, Ctrl_EX2;
    logic [159:0] Data_EX, Data_EX2;
    logic [15:0]  Stall_Count;
    logic [3:0]   Stall_Count2;
    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    id_ex_skid_stage dut (
        .Clk(Clk), .Reset(Reset), .Valid_ID(Valid_ID), .Ready_ID(Ready_ID),
        .Ctrl_ID(Ctrl_ID), .Data_ID(Data_ID), .Flush(Flush), .Valid_EX(Valid_EX),
        .Ready_EX(Ready_EX), .Ctrl_EX(Ctrl_EX), .Data_EX(Data_EX),
        .Count_Clear(Count_Clear), .Stall_Count(Stall_Count)
    );

    id_ex_skid_stage #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Valid_ID(Valid_ID), .Ready_ID(Ready_ID2),
        .Ctrl_ID(Ctrl_ID), .Data_ID(Data_ID), .Flush(Flush), .Valid_EX(Valid_EX2),
        .Ready_EX(Ready_EX), .Ctrl_EX(Ctrl_EX2), .Data_EX(Data_EX2),
        .Count_Clear(Count_Clear), .Stall_Count(Stall_Count2)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [8:0] c, input logic [31:0] w0);
        Valid_ID = v;
        Ctrl_ID  = c;
        Data_ID  = {128'h0, w0};
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", 64'(Valid_EX), 64'd0);
        chk("rst_ctrl", 64'(Ctrl_EX), 64'd0);
        chk("rst_data", Data_EX[63:0], 64'd0);
        chk("rst_cnt", 64'(Stall_Count), 64'd0);
        chk("rst_ready", 64'(Ready_ID), 64'd0);
        Reset = 1'b0;
        tick();
        chk("post_rst_ready", 64'(Ready_ID), 64'd1);

        Ready_EX = 1'b1;
        drive(1'b1, 9'h1A5, 32'h00400004);
        tick();
        chk("single_valid", 64'(Valid_EX), 64'd1);
        chk("single_ctrl", 64'(Ctrl_EX), 64'h1A5);
        chk("single_data", 64'(Data_EX[31:0]), 64'h00400004);
        drive(1'b0, 9'h0, 32'h0);
        tick();
        chk("single_gone_valid", 64'(Valid_EX), 64'd0);
        chk("single_gone_ctrl", 64'(Ctrl_EX), 64'd0);

        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 9'(i), 32'(i));
            tick();
            chk("stream_valid", 64'(Valid_EX), 64'd1);
            chk("stream_data", 64'(Data_EX[31:0]), 64'(i));
            chk("stream_ready", 64'(Ready_ID), 64'd1);
        end
        drive(1'b0, 9'h0, 32'h0);
        tick();
        chk("stream_end_valid", 64'(Valid_EX), 64'd0);
        chk("stream_cnt", 64'(Stall_Count), 64'd0);

        Ready_EX = 1'b0;
        drive(1'b1, 9'h0A1, 32'hA);
        tick();
        chk("bp_a_data", 64'(Data_EX[31:0]), 64'hA);
        chk("bp_a_ready", 64'(Ready_ID), 64'd1);
        drive(1'b1, 9'h152, 32'hB);
        tick();
        chk("bp_hold_a", 64'(Data_EX[31:0]), 64'hA);
        chk("bp_skid_ready", 64'(Ready_ID), 64'd0);
        chk("bp_cnt1", 64'(Stall_Count), 64'd1);
        drive(1'b1, 9'h0C3, 32'hC);
        tick();
        chk("bp_hold_a2", 64'(Data_EX[31:0]), 64'hA);
        chk("bp_ctrl_a", 64'(Ctrl_EX), 64'h0A1);
        chk("bp_ready_low", 64'(Ready_ID), 64'd0);
        chk("bp_cnt2", 64'(Stall_Count), 64'd2);
        Ready_EX = 1'b1;
        tick();
        chk("bp_out_b", 64'(Data_EX[31:0]), 64'hB);
        chk("bp_ctrl_b", 64'(Ctrl_EX), 64'h152);
        chk("bp_ready_back", 64'(Ready_ID), 64'd1);
        tick();
        chk("bp_out_c", 64'(Data_EX[31:0]), 64'hC);
        chk("bp_ctrl_c", 64'(Ctrl_EX), 64'h0C3);
        drive(1'b0, 9'h0, 32'h0);
        tick();
        chk("bp_drained", 64'(Valid_EX), 64'd0);
        chk("bp_cnt_final", 64'(Stall_Count), 64'd2);
        Count_Clear = 1'b1;
        tick();
        Count_Clear = 1'b0;
        chk("clear_cnt", 64'(Stall_Count), 64'd0);

        Ready_EX = 1'b0;
        drive(1'b1, 9'h0A1, 32'hA);
        tick();
        drive(1'b1, 9'h152, 32'hB);
        tick();
        chk("fl_skid_ready", 64'(Ready_ID), 64'd0);
        drive(1'b1, 9'h0C3, 32'hC);
        Ready_EX = 1'b1;
        Flush = 1'b1;
        chk("fl_a_presented", 64'(Data_EX[31:0]), 64'hA);
        chk("fl_a_valid", 64'(Valid_EX), 64'd1);
        tick();
        Flush = 1'b0;
        drive(1'b0, 9'h0, 32'h0);
        chk("fl_valid", 64'(Valid_EX), 64'd0);
        chk("fl_ctrl", 64'(Ctrl_EX), 64'd0);
        chk("fl_ready", 64'(Ready_ID), 64'd1);
        tick();
        chk("fl_no_b", 64'(Valid_EX), 64'd0);

        Ready_EX = 1'b0;
        drive(1'b1, 9'h0A1, 32'hA);
        tick();
        drive(1'b1, 9'h152, 32'hB);
        tick();
        chk("rs_skid_ready", 64'(Ready_ID), 64'd0);
        Reset = 1'b1;
        tick();
        chk("rs_valid", 64'(Valid_EX), 64'd0);
        chk("rs_ctrl", 64'(Ctrl_EX), 64'd0);
        chk("rs_data", Data_EX[63:0], 64'd0);
        chk("rs_cnt", 64'(Stall_Count), 64'd0);
        chk("rs_ready", 64'(Ready_ID), 64'd0);
        Reset = 1'b0;
        drive(1'b0, 9'h0, 32'h0);
        Ready_EX = 1'b1;
        tick();
        chk("rs_ready_back", 64'(Ready_ID), 64'd1);
        chk("rs_no_stale", 64'(Valid_EX), 64'd0);
        tick();
        chk("rs_no_stale2", 64'(Valid_EX), 64'd0);

        Ready_EX = 1'b0;
        drive(1'b1, 9'h0A1, 32'hA);
        tick();
        drive(1'b0, 9'h0, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt4", 64'(Stall_Count2), 64'd15);
        chk("sat_cnt16", 64'(Stall_Count), 64'd20);
        chk("sat_valid", 64'(Valid_EX2), 64'd1);
        Count_Clear = 1'b1;
        tick();
        Count_Clear = 1'b0;
        chk("sat_clear", 64'(Stall_Count2), 64'd0);
        tick();
        chk("sat_resume", 64'(Stall_Count2), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
